fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 10 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_unit.sv | 67 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch parameters, fetch-queue entry record and fetch FSM state type
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FQ_DEPTH = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
  } fetch_entry_t;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO with flush; head is the oldest entry
// ports: push_i/entry_i write, pop_i retires head, flush_i empties (wins over push/pop),
//        count_o occupancy, head_o oldest entry (zero after reset)
module fetch_queue import mips_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  parameter type T = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  T                             entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output T                             head_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem_q [DEPTH];
  logic [IW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return p == IW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_push = push_i & ~flush_i;
  assign do_pop = pop_i & ~flush_i & (cnt_q != '0);
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        wr_q <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with bounded in-flight requests and redirect flush
// ports: redirect_valid/redirect_pc from EX; imem_req/imem_addr issue, imem_rvalid/imem_rdata
//        in-order responses; ifid_valid/ifid_instr/ifid_pc_plus_four head entry, ifid_ready accept
module fetch_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int FQ_DEPTH = mips_pkg::FQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus_four,
  input  logic        ifid_ready
);
  import mips_pkg::*;
  localparam int CW = $clog2(FQ_DEPTH + 1);
  logic [31:0] pc_q, pc_d, inflight;
  logic [CW-1:0] stale_q, stale_d, count, outst;
  fetch_state_t state_q, state_d;
  fetch_entry_t head, rsp;
  logic en_q, pop, issue, accept;
  assign pop = ifid_valid & ifid_ready;
  // en_q holds requests off until the first edge after reset release
  assign issue = en_q & ~redirect_valid &
                 (({1'b0, outst} + {1'b0, count} - {{CW{1'b0}}, pop}) < (CW+1)'(FQ_DEPTH));
  // responses during a redirect or while stale fetches drain never enter the queue
  assign accept = imem_rvalid & ~redirect_valid & (state_q == RUN);
  assign rsp = '{instr: imem_rdata, pc_plus_four: inflight};
  assign imem_req = issue;
  assign imem_addr = pc_q;
  assign ifid_valid = count != '0;
  assign ifid_instr = head.instr;
  assign ifid_pc_plus_four = head.pc_plus_four;
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~32'd3) : issue ? pc_q + 32'd4 : pc_q;
    stale_d = redirect_valid ? outst - CW'(imem_rvalid) : stale_q - CW'(imem_rvalid && state_q == FLUSH);
    state_d = stale_d != '0 ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      stale_q <= '0;
      state_q <= RUN;
      en_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      stale_q <= stale_d;
      state_q <= state_d;
      en_q <= 1'b1;
    end
  end
  // in-flight fetch addresses (+4) in issue order; its occupancy is the outstanding count
  fetch_queue #(.DEPTH(FQ_DEPTH), .T(logic [31:0])) u_afq (
    .clk(clk), .rst_n(rst_n), .push_i(issue), .entry_i(pc_q + 32'd4), .pop_i(imem_rvalid),
    .flush_i(1'b0), .count_o(outst), .head_o(inflight)
  );
  fetch_queue #(.DEPTH(FQ_DEPTH), .T(fetch_entry_t)) u_ifq (
    .clk(clk), .rst_n(rst_n), .push_i(accept), .entry_i(rsp), .pop_i(pop),
    .flush_i(redirect_valid), .count_o(count), .head_o(head)
  );
endmodule
